// File: rtl/decode_if.sv
// Decode-stage bus: fetch inputs, writeback port, stall back to fetch
// and the decode->execute pipeline register outputs.
interface decode_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc_decode;
   logic [31:0]     instr_decode;
   logic            flush;
   logic            wb_en;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            stall;
   logic            valid_exe;
   logic [XLEN-1:0] pc_exe;
   logic [XLEN-1:0] rs1_data_exe;
   logic [XLEN-1:0] rs2_data_exe;
   logic [XLEN-1:0] imm_exe;
   logic [4:0]      rs1_exe;
   logic [4:0]      rs2_exe;
   logic [4:0]      rd_exe;
   logic [3:0]      alu_op_exe;
   logic            op_a_sel_exe;
   logic            op_b_sel_exe;
   logic [2:0]      br_type_exe;
   logic            mem_rd_exe;
   logic            mem_wr_exe;
   logic [2:0]      mem_size_exe;
   logic            reg_wr_exe;
   logic [1:0]      wb_sel_exe;

   modport master (
      output pc_decode, instr_decode, flush, wb_en, wb_addr, wb_data,
      input  stall, valid_exe, pc_exe, rs1_data_exe, rs2_data_exe, imm_exe,
             rs1_exe, rs2_exe, rd_exe, alu_op_exe, op_a_sel_exe, op_b_sel_exe,
             br_type_exe, mem_rd_exe, mem_wr_exe, mem_size_exe, reg_wr_exe,
             wb_sel_exe
   );

   modport slave (
      input  pc_decode, instr_decode, flush, wb_en, wb_addr, wb_data,
      output stall, valid_exe, pc_exe, rs1_data_exe, rs2_data_exe, imm_exe,
             rs1_exe, rs2_exe, rd_exe, alu_op_exe, op_a_sel_exe, op_b_sel_exe,
             br_type_exe, mem_rd_exe, mem_wr_exe, mem_size_exe, reg_wr_exe,
             wb_sel_exe
   );
endinterface

// File: rtl/decode.sv
// RV32I decode stage: register file, control/immediate decode, load-use
// stall with a one-entry replay buffer, branch flush, and decode->execute register.
module decode #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input logic    clk,
   input logic    rst,
   decode_if.slave bus
);
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      alu_op;
      logic            op_a_sel;
      logic            op_b_sel;
      logic [2:0]      br_type;
      logic            mem_rd;
      logic            mem_wr;
      logic [2:0]      mem_size;
      logic            reg_wr;
      logic [1:0]      wb_sel;
   } exe_t;

   logic [XLEN-1:0] regs [NREG];
   logic [XLEN-1:0] replay_pc;
   logic [31:0]     replay_instr;
   logic            replay_valid;
   logic            kill;
   exe_t            exe_q;
   exe_t            dec;
   logic [XLEN-1:0] cur_pc;
   logic [31:0]     cur_instr;
   logic            use_rs1;
   logic            use_rs2;
   logic            hazard;

   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                              input logic is_op);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
         3'b001:  op = 4'd2;
         3'b010:  op = 4'd3;
         3'b011:  op = 4'd4;
         3'b100:  op = 4'd5;
         3'b101:  op = alt ? 4'd7 : 4'd6;
         3'b110:  op = 4'd8;
         default: op = 4'd9;
      endcase
      return op;
   endfunction

   // Register file has no reset; x0 is never written and always reads zero.
   always_ff @(posedge clk) begin
      if (bus.wb_en && bus.wb_addr != 5'd0)
         regs[bus.wb_addr] <= bus.wb_data;
   end

   assign cur_pc    = replay_valid ? replay_pc : bus.pc_decode;
   assign cur_instr = replay_valid ? replay_instr : bus.instr_decode;

   always_comb begin
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      logic [4:0]  rs1_idx, rs2_idx;
      dec     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      imm_i   = {{20{cur_instr[31]}}, cur_instr[31:20]};
      imm_s   = {{20{cur_instr[31]}}, cur_instr[31:25], cur_instr[11:7]};
      imm_b   = {{19{cur_instr[31]}}, cur_instr[31], cur_instr[7], cur_instr[30:25],
                 cur_instr[11:8], 1'b0};
      imm_u   = {cur_instr[31:12], 12'b0};
      imm_j   = {{11{cur_instr[31]}}, cur_instr[31], cur_instr[19:12], cur_instr[20],
                 cur_instr[30:21], 1'b0};
      case (cur_instr[6:0])
         OPC_LUI: begin
            dec.valid = 1'b1; dec.alu_op = ALU_PASS_B; dec.op_b_sel = 1'b1;
            dec.imm = imm_u; dec.reg_wr = 1'b1;
         end
         OPC_AUIPC: begin
            dec.valid = 1'b1; dec.op_a_sel = 1'b1; dec.op_b_sel = 1'b1;
            dec.imm = imm_u; dec.reg_wr = 1'b1;
         end
         OPC_JAL: begin
            dec.valid = 1'b1; dec.op_a_sel = 1'b1; dec.op_b_sel = 1'b1;
            dec.imm = imm_j; dec.br_type = 3'd7; dec.reg_wr = 1'b1; dec.wb_sel = 2'd2;
         end
         OPC_JALR: begin
            dec.valid = 1'b1; dec.op_b_sel = 1'b1; dec.imm = imm_i; use_rs1 = 1'b1;
            dec.br_type = 3'd7; dec.reg_wr = 1'b1; dec.wb_sel = 2'd2;
         end
         OPC_BRANCH: begin
            dec.valid = 1'b1; dec.alu_op = ALU_SUB; dec.imm = imm_b;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            case (cur_instr[14:12])
               3'b000:  dec.br_type = 3'd1;
               3'b001:  dec.br_type = 3'd2;
               3'b100:  dec.br_type = 3'd3;
               3'b101:  dec.br_type = 3'd4;
               3'b110:  dec.br_type = 3'd5;
               3'b111:  dec.br_type = 3'd6;
               default: dec.br_type = 3'd0;
            endcase
         end
         OPC_LOAD: begin
            dec.valid = 1'b1; dec.op_b_sel = 1'b1; dec.imm = imm_i; use_rs1 = 1'b1;
            dec.mem_rd = 1'b1; dec.mem_size = cur_instr[14:12];
            dec.reg_wr = 1'b1; dec.wb_sel = 2'd1;
         end
         OPC_STORE: begin
            dec.valid = 1'b1; dec.op_b_sel = 1'b1; dec.imm = imm_s;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            dec.mem_wr = 1'b1; dec.mem_size = cur_instr[14:12];
         end
         OPC_OPIMM: begin
            dec.valid = 1'b1; dec.op_b_sel = 1'b1; dec.imm = imm_i; use_rs1 = 1'b1;
            dec.alu_op = alu_from_f3(cur_instr[14:12], cur_instr[30], 1'b0);
            dec.reg_wr = 1'b1;
         end
         OPC_OP: begin
            dec.valid = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            dec.alu_op = alu_from_f3(cur_instr[14:12], cur_instr[30], 1'b1);
            dec.reg_wr = 1'b1;
         end
         default: ;
      endcase
      // Unused source/destination fields are zeroed so forwarding never matches them.
      rs1_idx      = use_rs1 ? cur_instr[19:15] : 5'd0;
      rs2_idx      = use_rs2 ? cur_instr[24:20] : 5'd0;
      dec.rs1      = rs1_idx;
      dec.rs2      = rs2_idx;
      dec.rd       = dec.reg_wr ? cur_instr[11:7] : 5'd0;
      dec.pc       = dec.valid ? cur_pc : '0;
      dec.rs1_data = (rs1_idx == 5'd0) ? '0 :
                     (bus.wb_en && bus.wb_addr == rs1_idx) ? bus.wb_data : regs[rs1_idx];
      dec.rs2_data = (rs2_idx == 5'd0) ? '0 :
                     (bus.wb_en && bus.wb_addr == rs2_idx) ? bus.wb_data : regs[rs2_idx];
   end

   assign hazard = exe_q.valid && exe_q.mem_rd && exe_q.rd != 5'd0 &&
                   ((use_rs1 && dec.rs1 == exe_q.rd) || (use_rs2 && dec.rs2 == exe_q.rd));
   assign bus.stall = hazard && !bus.flush && !kill;

   // Flush beats kill beats stall; every squash path loads a zeroed bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_q        <= '0;
         replay_valid <= 1'b0;
         replay_pc    <= '0;
         replay_instr <= '0;
         kill         <= 1'b0;
      end else if (bus.flush) begin
         exe_q        <= '0;
         replay_valid <= 1'b0;
         kill         <= 1'b1;
      end else if (kill) begin
         exe_q        <= '0;
         replay_valid <= 1'b0;
         kill         <= 1'b0;
      end else if (bus.stall) begin
         exe_q        <= '0;
         replay_pc    <= cur_pc;
         replay_instr <= cur_instr;
         replay_valid <= 1'b1;
      end else begin
         exe_q        <= dec;
         replay_valid <= 1'b0;
      end
   end

   assign bus.valid_exe    = exe_q.valid;
   assign bus.pc_exe       = exe_q.pc;
   assign bus.rs1_data_exe = exe_q.rs1_data;
   assign bus.rs2_data_exe = exe_q.rs2_data;
   assign bus.imm_exe      = exe_q.imm;
   assign bus.rs1_exe      = exe_q.rs1;
   assign bus.rs2_exe      = exe_q.rs2;
   assign bus.rd_exe       = exe_q.rd;
   assign bus.alu_op_exe   = exe_q.alu_op;
   assign bus.op_a_sel_exe = exe_q.op_a_sel;
   assign bus.op_b_sel_exe = exe_q.op_b_sel;
   assign bus.br_type_exe  = exe_q.br_type;
   assign bus.mem_rd_exe   = exe_q.mem_rd;
   assign bus.mem_wr_exe   = exe_q.mem_wr;
   assign bus.mem_size_exe = exe_q.mem_size;
   assign bus.reg_wr_exe   = exe_q.reg_wr;
   assign bus.wb_sel_exe   = exe_q.wb_sel;
endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: decode fields, load-use replay,
// write-through, flush/kill and reset during a pending replay.
module tb_decode;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   decode_if #(.XLEN(32)) bus ();

   decode #(.XLEN(32), .NREG(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                                input logic fl);
      bus.pc_decode    = pc;
      bus.instr_decode = instr;
      bus.flush        = fl;
   endtask

   task automatic setWb(input logic en, input logic [4:0] addr, input logic [31:0] data);
      bus.wb_en   = en;
      bus.wb_addr = addr;
      bus.wb_data = data;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      applyStimulus(32'h0, 32'h0, 1'b0);
      setWb(1'b0, 5'd0, 32'h0);
      #3;
      checkOutput("reset_valid", 32'(bus.valid_exe), 32'h0);
      checkOutput("reset_pc", bus.pc_exe, 32'h0);
      checkOutput("reset_reg_wr", 32'(bus.reg_wr_exe), 32'h0);
      checkOutput("reset_stall", 32'(bus.stall), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // addi x1,x0,5 while writeback loads x1=0x100
      applyStimulus(32'h0, 32'h00500093, 1'b0);
      setWb(1'b1, 5'd1, 32'h00000100);
      step();
      checkOutput("addi_valid", 32'(bus.valid_exe), 32'h1);
      checkOutput("addi_rd", 32'(bus.rd_exe), 32'h1);
      checkOutput("addi_imm", bus.imm_exe, 32'h5);
      checkOutput("addi_alu", 32'(bus.alu_op_exe), 32'h0);
      checkOutput("addi_opb", 32'(bus.op_b_sel_exe), 32'h1);
      checkOutput("addi_regwr", 32'(bus.reg_wr_exe), 32'h1);

      // lui x5,0x12345
      applyStimulus(32'h4, 32'h123452B7, 1'b0);
      setWb(1'b0, 5'd0, 32'h0);
      step();
      checkOutput("lui_imm", bus.imm_exe, 32'h12345000);
      checkOutput("lui_alu", 32'(bus.alu_op_exe), 32'd10);
      checkOutput("lui_rd", 32'(bus.rd_exe), 32'd5);
      checkOutput("lui_pc", bus.pc_exe, 32'h4);

      // lw x2,0(x1)
      applyStimulus(32'h8, 32'h0000A103, 1'b0);
      step();
      checkOutput("lw_memrd", 32'(bus.mem_rd_exe), 32'h1);
      checkOutput("lw_rd", 32'(bus.rd_exe), 32'd2);
      checkOutput("lw_rs1data", bus.rs1_data_exe, 32'h00000100);
      checkOutput("lw_wbsel", 32'(bus.wb_sel_exe), 32'd1);
      checkOutput("lw_size", 32'(bus.mem_size_exe), 32'd2);

      // add x3,x2,x2 depends on the load
      applyStimulus(32'hC, 32'h002101B3, 1'b0);
      #1;
      checkOutput("hazard_stall", 32'(bus.stall), 32'h1);
      step();
      checkOutput("stall_bubble_valid", 32'(bus.valid_exe), 32'h0);
      checkOutput("stall_bubble_regwr", 32'(bus.reg_wr_exe), 32'h0);

      // fetch duplicate, writeback of x2 in the replay cycle
      setWb(1'b1, 5'd2, 32'hDEADBEEF);
      #1;
      checkOutput("replay_stall", 32'(bus.stall), 32'h0);
      step();
      checkOutput("add_valid", 32'(bus.valid_exe), 32'h1);
      checkOutput("add_pc", bus.pc_exe, 32'hC);
      checkOutput("add_rd", 32'(bus.rd_exe), 32'd3);
      checkOutput("add_rs1", 32'(bus.rs1_exe), 32'd2);
      checkOutput("add_rs2", 32'(bus.rs2_exe), 32'd2);
      checkOutput("add_rs1data", bus.rs1_data_exe, 32'hDEADBEEF);
      checkOutput("add_rs2data", bus.rs2_data_exe, 32'hDEADBEEF);
      checkOutput("add_opb", 32'(bus.op_b_sel_exe), 32'h0);

      // nop while writeback tries to write x0
      applyStimulus(32'h10, 32'h00000013, 1'b0);
      setWb(1'b1, 5'd0, 32'h7);
      step();
      checkOutput("nop_pc", bus.pc_exe, 32'h10);
      checkOutput("nop_valid", 32'(bus.valid_exe), 32'h1);

      // add x6,x0,x2
      applyStimulus(32'h14, 32'h00200333, 1'b0);
      setWb(1'b0, 5'd0, 32'h0);
      step();
      checkOutput("x0_read", bus.rs1_data_exe, 32'h0);
      checkOutput("x2_stored", bus.rs2_data_exe, 32'hDEADBEEF);
      checkOutput("add6_rd", 32'(bus.rd_exe), 32'd6);

      // flush with addi in decode, then wrong-path, then a real one
      applyStimulus(32'h18, 32'h00500093, 1'b1);
      step();
      checkOutput("flush_valid", 32'(bus.valid_exe), 32'h0);
      checkOutput("flush_regwr", 32'(bus.reg_wr_exe), 32'h0);
      applyStimulus(32'h1C, 32'h00700393, 1'b0);
      step();
      checkOutput("kill_valid", 32'(bus.valid_exe), 32'h0);
      applyStimulus(32'h20, 32'h00900413, 1'b0);
      step();
      checkOutput("postflush_valid", 32'(bus.valid_exe), 32'h1);
      checkOutput("postflush_pc", bus.pc_exe, 32'h20);
      checkOutput("postflush_imm", bus.imm_exe, 32'h9);

      // flush together with a load-use hazard
      applyStimulus(32'h24, 32'h0000A103, 1'b0);
      step();
      checkOutput("lw2_memrd", 32'(bus.mem_rd_exe), 32'h1);
      applyStimulus(32'h28, 32'h002101B3, 1'b1);
      #1;
      checkOutput("flush_over_stall", 32'(bus.stall), 32'h0);
      step();
      checkOutput("flush2_valid", 32'(bus.valid_exe), 32'h0);
      applyStimulus(32'h2C, 32'h002101B3, 1'b0);
      #1;
      checkOutput("kill_stall", 32'(bus.stall), 32'h0);
      step();
      checkOutput("kill2_valid", 32'(bus.valid_exe), 32'h0);

      // beq x1,x2,+8
      applyStimulus(32'h30, 32'h00208463, 1'b0);
      step();
      checkOutput("beq_br", 32'(bus.br_type_exe), 32'd1);
      checkOutput("beq_imm", bus.imm_exe, 32'h8);
      checkOutput("beq_rs2", 32'(bus.rs2_exe), 32'd2);
      checkOutput("beq_regwr", 32'(bus.reg_wr_exe), 32'h0);

      // sw x2,4(x1)
      applyStimulus(32'h34, 32'h0020A223, 1'b0);
      step();
      checkOutput("sw_memwr", 32'(bus.mem_wr_exe), 32'h1);
      checkOutput("sw_imm", bus.imm_exe, 32'h4);
      checkOutput("sw_rd", 32'(bus.rd_exe), 32'h0);

      // sub x3,x1,x2
      applyStimulus(32'h38, 32'h402081B3, 1'b0);
      step();
      checkOutput("sub_alu", 32'(bus.alu_op_exe), 32'd1);

      // addi x1,x0,-1
      applyStimulus(32'h3C, 32'hFFF00093, 1'b0);
      step();
      checkOutput("neg_imm", bus.imm_exe, 32'hFFFFFFFF);

      // jal x1,+16
      applyStimulus(32'h40, 32'h010000EF, 1'b0);
      step();
      checkOutput("jal_br", 32'(bus.br_type_exe), 32'd7);
      checkOutput("jal_wbsel", 32'(bus.wb_sel_exe), 32'd2);
      checkOutput("jal_opa", 32'(bus.op_a_sel_exe), 32'h1);
      checkOutput("jal_imm", bus.imm_exe, 32'h10);

      // all-zero instruction is a bubble
      applyStimulus(32'h44, 32'h00000000, 1'b0);
      step();
      checkOutput("illegal_valid", 32'(bus.valid_exe), 32'h0);
      checkOutput("illegal_pc", bus.pc_exe, 32'h0);

      // reset while a replay is pending
      applyStimulus(32'h48, 32'h0000A103, 1'b0);
      step();
      applyStimulus(32'h4C, 32'h002101B3, 1'b0);
      #1;
      checkOutput("rst_hazard_stall", 32'(bus.stall), 32'h1);
      step();
      rst = 1'b1;
      #1;
      checkOutput("midrst_valid", 32'(bus.valid_exe), 32'h0);
      checkOutput("midrst_pc", bus.pc_exe, 32'h0);
      checkOutput("midrst_stall", 32'(bus.stall), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(32'h80, 32'h00300493, 1'b0);
      step();
      checkOutput("postrst_pc", bus.pc_exe, 32'h80);
      checkOutput("postrst_rd", 32'(bus.rd_exe), 32'd9);
      checkOutput("postrst_imm", bus.imm_exe, 32'h3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
